// File: rtl/axi_build_info.sv
// rtl/axi_build_info.sv - AXI4-Lite build identity block: version, hash, user words, scratch, uptime
module axi_build_info #(
   parameter int                       ADDR_WIDTH   = 8,
   parameter logic [31:0]              VER_MAJOR    = '0,
   parameter logic [31:0]              VER_MINOR    = '0,
   parameter logic [31:0]              VER_BUILD    = '0,
   parameter logic [31:0]              VER_RCAND    = '0,
   parameter logic [31:0]              BUILD_DATE   = '0,
   parameter logic [31:0]              BUILD_TIME   = '0,
   parameter logic [31:0]              RTL_TYPE     = '0,
   parameter logic [31:0]              RTL_SUBTYPE  = '0,
   parameter int                       HASH_WORDS   = 5,
   parameter logic [HASH_WORDS*32-1:0] GIT_HASH     = '0,
   parameter int                       USER_WORDS   = 4,
   // Uptime start value at reset release (normally 0)
   parameter logic [63:0]              UPTIME_RESET = '0
) (
   input  logic                     AXI_ACLK,
   input  logic                     AXI_ARESETN,
   input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   input  logic [2:0]               S_AXI_ARPROT,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   input  logic [USER_WORDS*32-1:0] USER_INFO
);

   localparam logic [1:0]  OKAY   = 2'd0;
   localparam logic [1:0]  SLVERR = 2'd2;
   localparam logic [1:0]  DECERR = 2'd3;
   localparam int          IW     = ADDR_WIDTH - 2;
   localparam logic [31:0] CAPS   = {8'(HASH_WORDS), 8'(USER_WORDS), 16'h0002};

   typedef enum logic {R_IDLE, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;

   rd_state_t     rd_state;
   wr_state_t     wr_state;
   logic [31:0]   scratch;
   logic [63:0]   uptime;
   logic [31:0]   uptime_hi_shadow;
   logic [IW-1:0] ar_idx;
   logic [31:0]   rd_data_c;
   logic [1:0]    rd_resp_c;
   logic          ar_hs;
   logic [IW-1:0] awaddr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [IW-1:0] aw_idx_eff;
   logic [31:0]   wdata_eff;
   logic [3:0]    wstrb_eff;
   logic [1:0]    wr_resp_c;
   logic          wr_scratch_c;
   logic          aw_hs;
   logic          w_hs;
   logic          wr_commit;
   logic          unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], S_AXI_AWADDR[1:0]};

   assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign ar_hs  = (rd_state == R_IDLE) && S_AXI_ARVALID;

   always_comb begin
      rd_data_c = '0;
      rd_resp_c = DECERR;
      if (ar_idx < IW'(12)) begin
         rd_resp_c = OKAY;
         case (ar_idx[3:0])
            4'd0:    rd_data_c = VER_MAJOR;
            4'd1:    rd_data_c = VER_MINOR;
            4'd2:    rd_data_c = VER_BUILD;
            4'd3:    rd_data_c = VER_RCAND;
            4'd4:    rd_data_c = BUILD_DATE;
            4'd5:    rd_data_c = RTL_TYPE;
            4'd6:    rd_data_c = RTL_SUBTYPE;
            4'd7:    rd_data_c = BUILD_TIME;
            4'd8:    rd_data_c = scratch;
            4'd9:    rd_data_c = uptime[31:0];
            4'd10:   rd_data_c = uptime_hi_shadow;
            4'd11:   rd_data_c = CAPS;
            default: rd_data_c = '0;
         endcase
      end
      // Hash word 0 is the most significant word of GIT_HASH
      for (int i = 0; i < HASH_WORDS; i++) begin
         if (ar_idx == IW'(16 + i)) begin
            rd_data_c = GIT_HASH[(HASH_WORDS-1-i)*32 +: 32];
            rd_resp_c = OKAY;
         end
      end
      for (int i = 0; i < USER_WORDS; i++) begin
         if (ar_idx == IW'(32 + i)) begin
            rd_data_c = USER_INFO[32*i +: 32];
            rd_resp_c = OKAY;
         end
      end
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         rd_state      <= R_IDLE;
         S_AXI_ARREADY <= 1'b1;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= OKAY;
      end else begin
         case (rd_state)
            R_IDLE: if (S_AXI_ARVALID) begin
               S_AXI_RDATA   <= rd_data_c;
               S_AXI_RRESP   <= rd_resp_c;
               S_AXI_RVALID  <= 1'b1;
               S_AXI_ARREADY <= 1'b0;
               rd_state      <= R_RESP;
            end
            R_RESP: if (S_AXI_RREADY) begin
               S_AXI_RVALID  <= 1'b0;
               S_AXI_ARREADY <= 1'b1;
               rd_state      <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // Reading LO freezes HI so a LO-then-HI pair is coherent across a carry
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         uptime           <= UPTIME_RESET;
         uptime_hi_shadow <= '0;
      end else begin
         uptime <= uptime + 64'd1;
         if (ar_hs && (ar_idx == IW'(9)))
            uptime_hi_shadow <= uptime[63:32];
      end
   end

   assign aw_hs      = S_AXI_AWREADY && S_AXI_AWVALID;
   assign w_hs       = S_AXI_WREADY && S_AXI_WVALID;
   assign aw_idx_eff = (wr_state == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
   assign wdata_eff  = (wr_state == W_HAVE_W) ? wdata_q : S_AXI_WDATA;
   assign wstrb_eff  = (wr_state == W_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
   assign wr_commit  = ((wr_state == W_IDLE) && aw_hs && w_hs) ||
                       ((wr_state == W_HAVE_AW) && w_hs) ||
                       ((wr_state == W_HAVE_W) && aw_hs);

   always_comb begin
      wr_resp_c    = DECERR;
      wr_scratch_c = 1'b0;
      if (aw_idx_eff == IW'(8)) begin
         wr_resp_c    = OKAY;
         wr_scratch_c = 1'b1;
      end else if (aw_idx_eff < IW'(12)) begin
         wr_resp_c = SLVERR;
      end
      for (int i = 0; i < HASH_WORDS; i++)
         if (aw_idx_eff == IW'(16 + i)) wr_resp_c = SLVERR;
      for (int i = 0; i < USER_WORDS; i++)
         if (aw_idx_eff == IW'(32 + i)) wr_resp_c = SLVERR;
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         wr_state      <= W_IDLE;
         S_AXI_AWREADY <= 1'b1;
         S_AXI_WREADY  <= 1'b1;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= OKAY;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         scratch       <= '0;
      end else if (wr_commit) begin
         S_AXI_BRESP   <= wr_resp_c;
         S_AXI_BVALID  <= 1'b1;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         wr_state      <= W_RESP;
         if (wr_scratch_c) begin
            for (int k = 0; k < 4; k++)
               if (wstrb_eff[k]) scratch[8*k +: 8] <= wdata_eff[8*k +: 8];
         end
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  awaddr_q      <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                  S_AXI_AWREADY <= 1'b0;
                  wr_state      <= W_HAVE_AW;
               end else if (w_hs) begin
                  wdata_q      <= S_AXI_WDATA;
                  wstrb_q      <= S_AXI_WSTRB;
                  S_AXI_WREADY <= 1'b0;
                  wr_state     <= W_HAVE_W;
               end
            end
            W_RESP: if (S_AXI_BREADY) begin
               S_AXI_BVALID  <= 1'b0;
               S_AXI_AWREADY <= 1'b1;
               S_AXI_WREADY  <= 1'b1;
               wr_state      <= W_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_build_info.sv
// tb/tb_axi_build_info.sv - self-checking bench for axi_build_info
module tb_axi_build_info;

   localparam int          AW      = 9;
   localparam logic [31:0] P_MAJOR = 32'h0000_0003;
   localparam logic [31:0] P_MINOR = 32'h0000_0007;
   localparam logic [31:0] P_BUILD = 32'h0000_0123;
   localparam logic [31:0] P_RCAND = 32'h0000_0002;
   localparam logic [31:0] P_DATE  = 32'h2024_0611;
   localparam logic [31:0] P_TIME  = 32'h0013_4502;
   localparam logic [31:0] P_TYPE  = 32'h0000_00A1;
   localparam logic [31:0] P_SUB   = 32'h0000_0005;
   localparam logic [159:0] P_HASH = 160'h01234567_89ABCDEF_FEDCBA98_76543210_89ABCDEF;
   localparam logic [63:0] UP_INIT = 64'h0000_0000_FFFF_FF00;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] awaddr = '0, araddr = '0;
   logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [2:0]    awprot = '0, arprot = '0;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic [31:0]   user_w [4];
   logic [127:0]  user_info;

   logic [31:0]   hash_w [5] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'h89ABCDEF};
   logic [31:0]   m_scratch = '0;
   logic [31:0]   m_shadow = '0;
   logic [63:0]   cyc;
   int            vectors = 0;
   int            miscompares = 0;

   assign user_info = {user_w[3], user_w[2], user_w[1], user_w[0]};

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= '0;
      else        cyc <= cyc + 64'd1;

   axi_build_info #(
      .ADDR_WIDTH(AW), .VER_MAJOR(P_MAJOR), .VER_MINOR(P_MINOR), .VER_BUILD(P_BUILD),
      .VER_RCAND(P_RCAND), .BUILD_DATE(P_DATE), .BUILD_TIME(P_TIME), .RTL_TYPE(P_TYPE),
      .RTL_SUBTYPE(P_SUB), .HASH_WORDS(5), .GIT_HASH(P_HASH), .USER_WORDS(4),
      .UPTIME_RESET(UP_INIT)
   ) dut (
      .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWPROT(awprot),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(arprot), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .USER_INFO(user_info)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [1:0]    resp;
   } rvec_t;
   rvec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] up_now();
      return UP_INIT + cyc;
   endfunction

   function automatic logic [33:0] model_read(input logic [AW-1:0] a);
      int off;
      off = int'({a[AW-1:2], 2'b00});
      case (off)
         'h00: return {2'd0, P_MAJOR};
         'h04: return {2'd0, P_MINOR};
         'h08: return {2'd0, P_BUILD};
         'h0C: return {2'd0, P_RCAND};
         'h10: return {2'd0, P_DATE};
         'h14: return {2'd0, P_TYPE};
         'h18: return {2'd0, P_SUB};
         'h1C: return {2'd0, P_TIME};
         'h20: return {2'd0, m_scratch};
         'h24: return {2'd0, up_now() & 64'hFFFF_FFFF};
         'h28: return {2'd0, m_shadow};
         'h2C: return {2'd0, 32'h0504_0002};
         default: ;
      endcase
      if (off >= 'h40 && off < 'h40 + 4*5) return {2'd0, hash_w[(off - 'h40) / 4]};
      if (off >= 'h80 && off < 'h80 + 4*4) return {2'd0, user_w[(off - 'h80) / 4]};
      return {2'd3, 32'h0};
   endfunction

   function automatic logic [1:0] model_wresp(input logic [AW-1:0] a);
      logic [33:0] r;
      int off;
      off = int'({a[AW-1:2], 2'b00});
      if (off == 'h20) return 2'd0;
      r = model_read(a);
      return (r[33:32] == 2'd0) ? 2'd2 : 2'd3;
   endfunction

   task automatic rd_txn(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r,
                         output logic [33:0] e);
      logic [63:0] u;
      @(negedge clk);
      araddr = a; arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b0;
      e = model_read(a);
      u = up_now();
      if (a[AW-1:2] == 7'h09) m_shadow = u[63:32];
      chk("arready idle", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rvalid latency", rvalid, 1);
      chk("arready busy", arready, 0);
      d = rdata; r = rresp;
      @(negedge clk); rready = 1'b1;
      @(posedge clk); #1; rready = 1'b0;
      chk("rvalid drop", rvalid, 0);
   endtask

   task automatic rd_model(input logic [AW-1:0] a, output logic [31:0] d);
      logic [1:0]  r;
      logic [33:0] e;
      rd_txn(a, d, r, e);
      chk($sformatf("rdata @%0h", a), d, e[31:0]);
      chk($sformatf("rresp @%0h", a), r, e[33:32]);
   endtask

   // mode 0: AW and W together, 1: W three cycles ahead of AW, 2: AW two cycles ahead of W
   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int mode, input logic [1:0] exp_resp);
      int n;
      @(negedge clk);
      awprot = 3'($urandom);
      if (mode != 2) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      if (mode != 1) begin awaddr = a; awvalid = 1'b1; end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (mode == 1) begin
         chk("wready drop", wready, 0);
         chk("awready kept", awready, 1);
         repeat (2) @(posedge clk);
         @(negedge clk); awaddr = a; awvalid = 1'b1;
         @(posedge clk); #1; awvalid = 1'b0;
      end else if (mode == 2) begin
         chk("awready drop", awready, 0);
         chk("wready kept", wready, 1);
         @(posedge clk);
         @(negedge clk); wdata = d; wstrb = s; wvalid = 1'b1;
         @(posedge clk); #1; wvalid = 1'b0;
      end
      n = 0;
      while (!bvalid && n < 8) begin @(posedge clk); #1; n++; end
      chk("bvalid latency", n, 0);
      chk($sformatf("bresp @%0h", a), bresp, exp_resp);
      if (exp_resp == 2'd0 && a[AW-1:2] == 7'h08)
         for (int k = 0; k < 4; k++) if (s[k]) m_scratch[8*k +: 8] = d[8*k +: 8];
      @(negedge clk); bready = 1'b1;
      @(posedge clk); #1; bready = 1'b0;
      chk("bvalid drop", bvalid, 0);
      @(posedge clk); #1;
      chk("single bvalid", bvalid, 0);
      chk("awready back", awready, 1);
      chk("wready back", wready, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst arready", arready, 1);
      chk("rst awready", awready, 1);
      chk("rst wready", wready, 1);
      chk("rst rvalid", rvalid, 0);
      chk("rst bvalid", bvalid, 0);
      chk("rst rdata", rdata, 0);
      chk("rst rresp", rresp, 0);
      chk("rst bresp", bresp, 0);
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      m_scratch = '0; m_shadow = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [33:0] e;
      int          n;
      logic [AW-1:0] a;
      logic [AW-1:0] pick [8] = '{9'h020, 9'h024, 9'h028, 9'h000, 9'h04C, 9'h08C, 9'h054, 9'h100};

      user_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hA5A5A5A5};
      #2;
      do_reset();

      tbl.push_back('{9'h000, P_MAJOR, 2'd0});
      tbl.push_back('{9'h004, P_MINOR, 2'd0});
      tbl.push_back('{9'h008, P_BUILD, 2'd0});
      tbl.push_back('{9'h00C, P_RCAND, 2'd0});
      tbl.push_back('{9'h010, P_DATE, 2'd0});
      tbl.push_back('{9'h014, P_TYPE, 2'd0});
      tbl.push_back('{9'h018, P_SUB, 2'd0});
      tbl.push_back('{9'h01F, P_TIME, 2'd0});
      tbl.push_back('{9'h020, 32'h0, 2'd0});
      tbl.push_back('{9'h028, 32'h0, 2'd0});
      tbl.push_back('{9'h02C, 32'h0504_0002, 2'd0});
      tbl.push_back('{9'h030, 32'h0, 2'd3});
      tbl.push_back('{9'h03C, 32'h0, 2'd3});
      tbl.push_back('{9'h040, 32'h01234567, 2'd0});
      tbl.push_back('{9'h044, 32'h89ABCDEF, 2'd0});
      tbl.push_back('{9'h048, 32'hFEDCBA98, 2'd0});
      tbl.push_back('{9'h04C, 32'h76543210, 2'd0});
      tbl.push_back('{9'h050, 32'h89ABCDEF, 2'd0});
      tbl.push_back('{9'h054, 32'h0, 2'd3});
      tbl.push_back('{9'h080, 32'h11111111, 2'd0});
      tbl.push_back('{9'h08C, 32'hA5A5A5A5, 2'd0});
      tbl.push_back('{9'h090, 32'h0, 2'd3});
      tbl.push_back('{9'h100, 32'h0, 2'd3});
      tbl.push_back('{9'h1FC, 32'h0, 2'd3});
      foreach (tbl[i]) begin
         rd_txn(tbl[i].addr, d, r, e);
         chk($sformatf("tbl rdata @%0h", tbl[i].addr), d, tbl[i].data);
         chk($sformatf("tbl rresp @%0h", tbl[i].addr), r, tbl[i].resp);
      end

      wr(9'h020, 32'hDEADBEEF, 4'hF, 0, 2'd0);
      wr(9'h020, 32'h11223344, 4'h5, 0, 2'd0);
      rd_model(9'h020, d);
      chk("scratch strobes", d, 32'hDE22BE44);
      wr(9'h020, 32'h55AA_55AA, 4'hF, 1, 2'd0);
      wr(9'h020, 32'h0F0F_0F0F, 4'hA, 2, 2'd0);
      rd_model(9'h020, d);
      chk("scratch order", d, 32'h0FAA_0FAA);
      wr(9'h000, 32'hFFFF_FFFF, 4'hF, 0, 2'd2);
      rd_model(9'h000, d);
      chk("ro unchanged", d, P_MAJOR);
      wr(9'h100, 32'h1, 4'hF, 1, 2'd3);
      wr(9'h084, 32'h1, 4'hF, 2, 2'd2);

      // Scratch read accepted in the same cycle the write commits sees the old value
      @(negedge clk);
      awaddr = 9'h020; awvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
      araddr = 9'h020; arvalid = 1; rready = 0;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      chk("concurrent rvalid", rvalid, 1);
      chk("concurrent rdata", rdata, 32'h0FAA_0FAA);
      chk("concurrent bvalid", bvalid, 1);
      chk("concurrent bresp", bresp, 0);
      @(negedge clk); bready = 1; rready = 1;
      @(posedge clk); #1; bready = 0; rready = 0;
      m_scratch = 32'h1234_5678;
      rd_model(9'h020, d);

      // RREADY held low: data stays, no new AR taken
      @(negedge clk); araddr = 9'h02C; arvalid = 1; rready = 0;
      @(posedge clk); #1; arvalid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); araddr = 9'h000; arvalid = 1;
         chk("hold rvalid", rvalid, 1);
         chk("hold rdata", rdata, 32'h0504_0002);
         chk("hold arready", arready, 0);
      end
      @(negedge clk); arvalid = 0; rready = 1;
      @(posedge clk); #1; rready = 0;
      chk("hold release", rvalid, 0);

      // Randomized traffic against the model
      for (int it = 0; it < 80; it++) begin
         n = $urandom_range(0, 9);
         a = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : AW'($urandom_range(0, 511));
         if (n < 5) begin
            rd_model(a, d);
         end else if (n < 9) begin
            if (n == 8) a = 9'h020;
            wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), model_wresp(a));
         end else begin
            @(negedge clk);
            user_w[$urandom_range(0, 3)] = $urandom;
         end
      end

      // Uptime LO/HI across the 32-bit carry
      do_reset();
      n = 0;
      while (cyc != 64'hFD && n < 1000) begin @(negedge clk); n++; end
      chk("uptime wait", n < 1000, 1);
      rd_model(9'h024, d);
      chk("uptime lo pre-wrap", d, 32'hFFFF_FFFE);
      rd_model(9'h028, d);
      chk("uptime hi shadow", d, 32'h0);
      rd_model(9'h024, d);
      rd_model(9'h028, d);
      chk("uptime hi post-wrap", d, 32'h1);

      // Reset mid-read and mid-write aborts without a response
      @(negedge clk); araddr = 9'h000; arvalid = 1; rready = 0;
      @(posedge clk); #1; arvalid = 0;
      chk("pre-reset rvalid", rvalid, 1);
      #2;
      do_reset();
      rd_model(9'h020, d);
      chk("scratch after reset", d, 32'h0);
      @(negedge clk); awaddr = 9'h020; awvalid = 1;
      @(posedge clk); #1; awvalid = 0;
      chk("pre-reset awready", awready, 0);
      #2;
      do_reset();
      wr(9'h020, 32'hCAFE_F00D, 4'hF, 0, 2'd0);
      rd_model(9'h020, d);
      chk("post-reset write", d, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
